// File: rtl/girl10_monitor_if.sv
// Observation stream of the girl10 controller: one x/y step per valid cycle.
interface girl10_monitor_if;
  logic       obs_valid;
  logic [6:0] x_in;
  logic [8:0] y_obs;

  modport master (output obs_valid, x_in, y_obs);
  modport slave  (input  obs_valid, x_in, y_obs);
endinterface

// File: rtl/girl10_monitor.sv
// Passive golden-model observer for the girl10 six-state Mealy controller.
// Tracks the expected state, compares predicted against observed outputs and keeps error status.
module girl10_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ALARM_TH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  girl10_monitor_if.slave      obs,
  input  logic                 clr_err,
  output logic [2:0]           exp_state,
  output logic [8:0]           exp_y,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic                 alarm,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [2:0]           first_state,
  output logic [8:0]           first_exp_y,
  output logic [8:0]           first_obs_y
);

  typedef enum logic [2:0] {
    StS1 = 3'd1,
    StS2 = 3'd2,
    StS3 = 3'd3,
    StS4 = 3'd4,
    StS5 = 3'd5,
    StS6 = 3'd6
  } state_e;

  // Output bit positions in the packed {y10,y9,y8,y7,y6,y4,y3,y2,y1} vector.
  localparam logic [8:0] Y1  = 9'h001;
  localparam logic [8:0] Y2  = 9'h002;
  localparam logic [8:0] Y3  = 9'h004;
  localparam logic [8:0] Y4  = 9'h008;
  localparam logic [8:0] Y6  = 9'h010;
  localparam logic [8:0] Y7  = 9'h020;
  localparam logic [8:0] Y8  = 9'h040;
  localparam logic [8:0] Y9  = 9'h080;
  localparam logic [8:0] Y10 = 9'h100;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] AlarmTh = CNT_W'(ALARM_TH);

  state_e           state_q, state_d, state_nxt;
  logic [8:0]       pred;
  logic             illegal;
  logic             sample_bad;
  logic [8:0]       exp_y_q, exp_y_d;
  logic             mismatch_q, mismatch_d;
  logic             err_q, err_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] consec_q, consec_d;
  logic [2:0]       fs_q, fs_d;
  logic [8:0]       fe_q, fe_d;
  logic [8:0]       fo_q, fo_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  // Golden transition/output table; x_in bit0 is x1.
  always_comb begin
    pred      = '0;
    state_nxt = StS1;
    illegal   = 1'b0;
    case (state_q)
      StS1: begin
        if (obs.x_in[5]) begin
          pred = Y8 | Y9;        state_nxt = StS2;
        end else if (obs.x_in[6]) begin
          pred = Y6;             state_nxt = StS3;
        end else begin
          pred = Y3 | Y6 | Y10;  state_nxt = StS3;
        end
      end
      StS2: begin
        if (obs.x_in[3] && obs.x_in[0]) begin
          pred = Y1 | Y2;        state_nxt = StS2;
        end else if (obs.x_in[3]) begin
          pred = Y3 | Y4;        state_nxt = StS4;
        end else begin
          pred = Y4;             state_nxt = StS5;
        end
      end
      StS3: begin
        if (!obs.x_in[0]) begin
          pred = Y4;             state_nxt = StS5;
        end else if (obs.x_in[1] && !obs.x_in[2]) begin
          pred = Y6 | Y7;        state_nxt = StS6;
        end else begin
          pred = Y1 | Y3;        state_nxt = StS2;
        end
      end
      StS4: begin
        if (obs.x_in[5]) begin
          pred = Y6 | Y7;        state_nxt = StS3;
        end else begin
          pred = Y3 | Y4;        state_nxt = StS4;
        end
      end
      StS5: begin
        if (obs.x_in[4]) begin
          pred = '0;             state_nxt = StS1;
        end else if (obs.x_in[0]) begin
          pred = Y8 | Y9;        state_nxt = StS2;
        end else begin
          pred = Y3 | Y4;        state_nxt = StS4;
        end
      end
      StS6: begin
        pred = Y3 | Y4;          state_nxt = StS4;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign sample_bad = illegal || (pred != obs.y_obs);

  // clr_err acts before the current sample, so a mismatch in the same cycle starts a fresh record.
  always_comb begin
    state_d    = state_q;
    exp_y_d    = exp_y_q;
    mismatch_d = 1'b0;
    cyc_d      = cyc_q;
    err_d      = err_q;
    alarm_d    = alarm_q;
    mcnt_d     = mcnt_q;
    consec_d   = consec_q;
    fs_d       = fs_q;
    fe_d       = fe_q;
    fo_d       = fo_q;
    if (clr_err) begin
      err_d    = 1'b0;
      alarm_d  = 1'b0;
      mcnt_d   = '0;
      consec_d = '0;
      fs_d     = '0;
      fe_d     = '0;
      fo_d     = '0;
    end
    if (obs.obs_valid) begin
      state_d = state_nxt;
      exp_y_d = pred;
      cyc_d   = sat_inc(cyc_q);
      if (sample_bad) begin
        mismatch_d = 1'b1;
        if (!err_d) begin
          fs_d = state_q;
          fe_d = pred;
          fo_d = obs.y_obs;
        end
        err_d    = 1'b1;
        mcnt_d   = sat_inc(mcnt_d);
        consec_d = sat_inc(consec_d);
        if (consec_d >= AlarmTh) begin
          alarm_d = 1'b1;
        end
      end else begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StS1;
      exp_y_q    <= '0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      alarm_q    <= 1'b0;
      mcnt_q     <= '0;
      cyc_q      <= '0;
      consec_q   <= '0;
      fs_q       <= '0;
      fe_q       <= '0;
      fo_q       <= '0;
    end else begin
      state_q    <= state_d;
      exp_y_q    <= exp_y_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      alarm_q    <= alarm_d;
      mcnt_q     <= mcnt_d;
      cyc_q      <= cyc_d;
      consec_q   <= consec_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      fo_q       <= fo_d;
    end
  end

  assign exp_state    = state_q;
  assign exp_y        = exp_y_q;
  assign mismatch     = mismatch_q;
  assign err_sticky   = err_q;
  assign alarm        = alarm_q;
  assign mismatch_cnt = mcnt_q;
  assign cycle_cnt    = cyc_q;
  assign first_state  = fs_q;
  assign first_exp_y  = fe_q;
  assign first_obs_y  = fo_q;

endmodule

// File: tb/tb_girl10_monitor.sv
// Self-checking bench for girl10_monitor: directed scenarios plus randomized traffic
// checked against a behavioural model of the golden table and error bookkeeping.
module tb_girl10_monitor;

  localparam int CntMax  = 255;
  localparam int AlarmTh = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] exp_state;
  logic [8:0] exp_y;
  logic       mismatch, err_sticky, alarm;
  logic [7:0] mismatch_cnt, cycle_cnt;
  logic [2:0] first_state;
  logic [8:0] first_exp_y, first_obs_y;

  int tests = 0;
  int fails = 0;

  // Model state
  int         m_state;
  logic [8:0] m_y;
  bit         m_mis, m_err, m_alarm;
  int         m_mcnt, m_cyc, m_consec, m_fs;
  logic [8:0] m_fe, m_fo;
  logic [8:0] last_y;

  girl10_monitor_if obs ();

  girl10_monitor #(.CNT_W(8), .ALARM_TH(AlarmTh)) dut (
    .clk          (clk),
    .rst          (rst),
    .obs          (obs.slave),
    .clr_err      (clr_err),
    .exp_state    (exp_state),
    .exp_y        (exp_y),
    .mismatch     (mismatch),
    .err_sticky   (err_sticky),
    .alarm        (alarm),
    .mismatch_cnt (mismatch_cnt),
    .cycle_cnt    (cycle_cnt),
    .first_state  (first_state),
    .first_exp_y  (first_exp_y),
    .first_obs_y  (first_obs_y)
  );

  always #5 clk = ~clk;

  logic [51:0] act;
  assign act = {exp_state, exp_y, mismatch, err_sticky, alarm, mismatch_cnt, cycle_cnt,
                first_state, first_exp_y, first_obs_y};

  function automatic logic [51:0] mdl_vec();
    return {3'(m_state), m_y, m_mis, m_err, m_alarm, 8'(m_mcnt), 8'(m_cyc),
            3'(m_fs), m_fe, m_fo};
  endfunction

  // Table in terms of named y outputs; x[k-1] is x_k.
  function automatic void golden(input int s, input logic [6:0] x,
                                 output int ns, output logic [8:0] y, output bit ill);
    int ys[$];
    ill = 0;
    ns  = 1;
    if (s == 1) begin
      if (x[5])      begin ys = '{8, 9};     ns = 2; end
      else if (x[6]) begin ys = '{6};        ns = 3; end
      else           begin ys = '{3, 6, 10}; ns = 3; end
    end else if (s == 2) begin
      if (x[3] && x[0]) begin ys = '{1, 2}; ns = 2; end
      else if (x[3])    begin ys = '{3, 4}; ns = 4; end
      else              begin ys = '{4};    ns = 5; end
    end else if (s == 3) begin
      if (x[0] && x[1] && x[2])  begin ys = '{1, 3}; ns = 2; end
      else if (x[0] && x[1])     begin ys = '{6, 7}; ns = 6; end
      else if (x[0])             begin ys = '{1, 3}; ns = 2; end
      else                       begin ys = '{4};    ns = 5; end
    end else if (s == 4) begin
      if (x[5]) begin ys = '{6, 7}; ns = 3; end
      else      begin ys = '{3, 4}; ns = 4; end
    end else if (s == 5) begin
      if (x[4])      begin ns = 1; end
      else if (x[0]) begin ys = '{8, 9}; ns = 2; end
      else           begin ys = '{3, 4}; ns = 4; end
    end else if (s == 6) begin
      ys = '{3, 4}; ns = 4;
    end else begin
      ill = 1;
    end
    y = '0;
    foreach (ys[i]) begin
      // Packed order skips y5: y1..y4 -> bits 0..3, y6..y10 -> bits 4..8.
      if (ys[i] <= 4) y[ys[i]-1] = 1'b1;
      else            y[ys[i]-2] = 1'b1;
    end
  endfunction

  function automatic void mdl_reset();
    m_state = 1; m_y = '0; m_mis = 0; m_err = 0; m_alarm = 0;
    m_mcnt = 0; m_cyc = 0; m_consec = 0; m_fs = 0; m_fe = '0; m_fo = '0;
  endfunction

  // ymode: 0 = golden y, 1 = inverted golden y, 2 = ylit
  task automatic step(input bit v, input logic [6:0] x, input int ymode,
                      input logic [8:0] ylit, input bit c, input bit r);
    int ns;
    logic [8:0] p;
    bit ill, bad;
    @(negedge clk);
    golden(m_state, x, ns, p, ill);
    last_y = (ymode == 0) ? p : (ymode == 1) ? ~p : ylit;
    obs.obs_valid = v;
    obs.x_in      = x;
    obs.y_obs     = last_y;
    clr_err       = c;
    rst           = r;
    if (r) begin
      mdl_reset();
    end else begin
      if (c) begin
        m_err = 0; m_alarm = 0; m_mcnt = 0; m_consec = 0; m_fs = 0; m_fe = '0; m_fo = '0;
      end
      m_mis = 0;
      if (v) begin
        bad   = ill || (p != last_y);
        m_cyc = (m_cyc < CntMax) ? m_cyc + 1 : CntMax;
        if (bad) begin
          if (!m_err) begin m_fs = m_state; m_fe = p; m_fo = last_y; end
          m_err    = 1;
          m_mis    = 1;
          m_mcnt   = (m_mcnt < CntMax) ? m_mcnt + 1 : CntMax;
          m_consec = (m_consec < CntMax) ? m_consec + 1 : CntMax;
          if (m_consec >= AlarmTh) m_alarm = 1;
        end else begin
          m_consec = 0;
        end
        m_y     = p;
        m_state = ns;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 7'h00, 2, 9'h000, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 7'h00, 2, 9'h000, 0, 1);
    step(0, 7'h00, 2, 9'h000, 0, 0);
    tests++;
    if (act !== {3'd1, 49'd0}) begin
      fails++; $display("FAIL reset: got %h want %h", act, {3'd1, 49'd0});
    end
  endtask

  task automatic test_first_step();
    step(1, 7'b0100000, 2, 9'h0C0, 0, 0);
    tests++;
    if ({mismatch, exp_state, exp_y, cycle_cnt} !== {1'b0, 3'd2, 9'h0C0, 8'd1}) begin
      fails++;
      $display("FAIL first_step: mis=%0d st=%0d y=%h cyc=%0d want 0 2 0c0 1",
               mismatch, exp_state, exp_y, cycle_cnt);
    end
  endtask

  task automatic test_golden_path();
    logic [6:0] xs[3] = '{7'b0000000, 7'b0000011, 7'b1010101};
    logic [8:0] ys[3] = '{9'h114, 9'h030, 9'h00C};
    int         st[3] = '{3, 6, 4};
    step(0, 7'h00, 2, 9'h000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, xs[i], 2, ys[i], 0, 0);
      tests++;
      if ({exp_state, err_sticky} !== {3'(st[i]), 1'b0}) begin
        fails++;
        $display("FAIL golden_path[%0d]: st=%0d err=%0d want %0d 0", i, exp_state,
                 err_sticky, st[i]);
      end
    end
    tests++;
    if (cycle_cnt !== 8'd3) begin
      fails++; $display("FAIL golden_path_cyc: got %0d want 3", cycle_cnt);
    end
  endtask

  task automatic test_first_capture();
    step(0, 7'h00, 2, 9'h000, 0, 1);
    step(1, 7'b0100000, 2, 9'h0C0, 0, 0);  // S1 -> S2
    step(1, 7'b0000000, 2, 9'h008, 0, 0);  // S2 -> S5
    step(1, 7'b0010000, 2, 9'h000, 0, 0);  // S5 -> S1, no outputs
    tests++;
    if ({exp_state, err_sticky} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL s5_return: st=%0d err=%0d want 1 0", exp_state, err_sticky);
    end
    step(1, 7'b0100000, 2, 9'h000, 0, 0);
    tests++;
    if ({mismatch, first_state, first_exp_y, first_obs_y, mismatch_cnt}
        !== {1'b1, 3'd1, 9'h0C0, 9'h000, 8'd1}) begin
      fails++;
      $display("FAIL first_capture: mis=%0d fs=%0d fe=%h fo=%h cnt=%0d want 1 1 0c0 000 1",
               mismatch, first_state, first_exp_y, first_obs_y, mismatch_cnt);
    end
    step(1, 7'b0000000, 1, 9'h000, 0, 0);
    tests++;
    if ({first_state, first_exp_y, mismatch_cnt} !== {3'd1, 9'h0C0, 8'd2}) begin
      fails++;
      $display("FAIL first_hold: fs=%0d fe=%h cnt=%0d want 1 0c0 2",
               first_state, first_exp_y, mismatch_cnt);
    end
  endtask

  task automatic test_alarm();
    step(0, 7'h00, 2, 9'h000, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 7'($urandom), 1, 9'h000, 0, 0);
    tests++;
    if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_3: got %0d want 0", alarm); end
    step(1, 7'($urandom), 0, 9'h000, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7'($urandom), 1, 9'h000, 0, 0);
    tests++;
    if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_restart: got %0d want 0", alarm); end
    step(1, 7'($urandom), 1, 9'h000, 0, 0);
    tests++;
    if (alarm !== 1'b1) begin fails++; $display("FAIL alarm_4: got %0d want 1", alarm); end
    step(1, 7'($urandom), 0, 9'h000, 0, 0);
    tests++;
    if (act !== mdl_vec()) begin
      fails++; $display("FAIL alarm_sticky: got %h want %h", act, mdl_vec());
    end
  endtask

  task automatic test_clr_err();
    logic [2:0] st;
    step(0, 7'h00, 2, 9'h000, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 7'($urandom), 1, 9'h000, 0, 0);
    tests++;
    if (mismatch_cnt !== 8'd5) begin
      fails++; $display("FAIL clr_pre: got %0d want 5", mismatch_cnt);
    end
    st = exp_state;
    step(1, 7'($urandom), 1, 9'h000, 1, 0);
    tests++;
    if ({mismatch_cnt, err_sticky, alarm, first_state, first_obs_y}
        !== {8'd1, 1'b1, 1'b0, st, last_y}) begin
      fails++;
      $display("FAIL clr_with_mis: cnt=%0d err=%0d al=%0d fs=%0d fo=%h want 1 1 0 %0d %h",
               mismatch_cnt, err_sticky, alarm, first_state, first_obs_y, st, last_y);
    end
    st = exp_state;
    step(0, 7'h00, 2, 9'h000, 1, 0);
    tests++;
    if ({err_sticky, alarm, mismatch_cnt, first_state, first_exp_y, first_obs_y, exp_state}
        !== {32'd0, st}) begin
      fails++;
      $display("FAIL clr_idle: err=%0d al=%0d cnt=%0d st=%0d want 0 0 0 %0d",
               err_sticky, alarm, mismatch_cnt, exp_state, st);
    end
  endtask

  task automatic test_rst_mid();
    step(0, 7'h00, 2, 9'h000, 0, 1);
    step(1, 7'b0100000, 0, 9'h000, 0, 0);  // S2
    step(1, 7'b0001000, 1, 9'h000, 0, 0);  // S4 with a mismatch on record
    step(1, 7'($urandom), 1, 9'h000, 0, 1);
    tests++;
    if (act !== {3'd1, 49'd0}) begin
      fails++; $display("FAIL rst_mid: got %h want %h", act, {3'd1, 49'd0});
    end
    step(1, 7'b0100000, 0, 9'h000, 0, 0);
    idle(10);
    tests++;
    if ({exp_state, cycle_cnt, mismatch} !== {3'd2, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL idle_hold: st=%0d cyc=%0d mis=%0d want 2 1 0",
               exp_state, cycle_cnt, mismatch);
    end
  endtask

  task automatic test_saturation();
    step(0, 7'h00, 2, 9'h000, 0, 1);
    for (int i = 0; i < 260; i++) step(1, 7'($urandom), 1, 9'h000, 0, 0);
    tests++;
    if ({mismatch_cnt, cycle_cnt, alarm} !== {8'd255, 8'd255, 1'b1}) begin
      fails++;
      $display("FAIL saturation: cnt=%0d cyc=%0d al=%0d want 255 255 1",
               mismatch_cnt, cycle_cnt, alarm);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 90, 7'($urandom), (r % 4 == 0) ? 2 : 0, 9'($urandom),
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
      tests++;
      if (act !== mdl_vec()) begin
        fails++; $display("FAIL random[%0d]: got %h want %h", i, act, mdl_vec());
      end
    end
  endtask

  initial begin
    obs.obs_valid = 1'b0;
    obs.x_in      = '0;
    obs.y_obs     = '0;
    mdl_reset();
    test_reset();
    test_first_step();
    test_golden_path();
    test_first_capture();
    test_alarm();
    test_clr_err();
    test_rst_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
